fetch_unit: RTL

Instruction-fetch and program-counter sequencer for the 9-bit-instruction core. It sits directly upstream of the `Control` decoder. It drives the instruction-ROM address and hands the fetched word's 6-bit opcode to `Control`. It consumes the `branch`/`taken` pair that `Control` returns to pick the next PC. It also owns the start/halt/done handshake with the testbench.

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_unit_if.sv | 37 +++
 rtl/fetch_unit_branch_lut.sv | 15 +
 rtl/fetch_unit.sv | 90 +++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch unit: state encoding, HALT opcode,
// branch-target table and width defaults.
package fetch_pkg;

    localparam int PC_W_DEF    = 10;
    localparam int INSTR_W_DEF = 9;
    localparam int LUT_AW_DEF  = 5;
    localparam int OPC_W       = 6;
    localparam int CNT_W       = 16;

    localparam logic [OPC_W-1:0] OP_HALT = 6'b110_111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

    // Redirect targets, indexed by {opcode[1:0], operand[2:0]}.
    localparam logic [PC_W_DEF-1:0] BRANCH_TARGETS [32] = '{
        10'd16,  10'd24,  10'd32,  10'd40,  10'd48,  10'd56,  10'd64,  10'd72,
        10'd80,  10'd88,  10'd96,  10'd104, 10'd112, 10'd120, 10'd128, 10'd136,
        10'd144, 10'd152, 10'd160, 10'd168, 10'd176, 10'd184, 10'd192, 10'd200,
        10'd208, 10'd216, 10'd224, 10'd232, 10'd240, 10'd248, 10'd256, 10'd264
    };

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit <-> ROM/Control/testbench signal bundle.
// cycle_count is present only when FETCH_CYCLE_COUNT_EN is defined.
interface fetch_unit_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9
);
    logic               start;
    logic [PC_W-1:0]    start_addr;
    logic               stall;
    logic [INSTR_W-1:0] instr;
    logic               branch;
    logic               taken;
    logic [PC_W-1:0]    instr_addr;
    logic [5:0]         opcode;
    logic               running;
    logic               done;
`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0]        cycle_count;
`endif

    modport master (
        output start, start_addr, stall, instr, branch, taken,
`ifdef FETCH_CYCLE_COUNT_EN
        input  cycle_count,
`endif
        input  instr_addr, opcode, running, done
    );

    modport slave (
        input  start, start_addr, stall, instr, branch, taken,
`ifdef FETCH_CYCLE_COUNT_EN
        output cycle_count,
`endif
        output instr_addr, opcode, running, done
    );

endinterface

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target ROM: maps the 5-bit LUT index to a PC target.
// Latency: combinational. Backpressure: none.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic [LUT_AW-1:0] idx,
    output logic [PC_W-1:0]   target
);

    assign target = PC_W'(BRANCH_TARGETS[idx]);

endmodule

// File: rtl/fetch_unit.sv
// PC sequencer with IDLE/RUN/HALTED control; optional counter via FETCH_CYCLE_COUNT_EN.
// Latency: next PC registered one edge after the fetch, zero-cycle branch penalty.
// Backpressure: stall freezes PC and state; the cycle counter keeps running in RUN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int LUT_AW  = LUT_AW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.slave  bus
);

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   lut_target;
    logic [OPC_W-1:0]  instr_op;
    logic              start_ok;

    assign instr_op = bus.instr[INSTR_W-1 -: OPC_W];
    assign start_ok = bus.start && (state_q != RUN);

    branch_lut #(
        .PC_W   (PC_W),
        .LUT_AW (LUT_AW)
    ) u_branch_lut (
        .idx    (bus.instr[LUT_AW-1:0]),
        .target (lut_target)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE, HALTED: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = bus.start_addr;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    // HALT takes precedence over any redirect and leaves PC on the HALT word.
                    if (instr_op == OP_HALT) begin
                        state_d = HALTED;
                    end else if (bus.branch && bus.taken) begin
                        pc_d = lut_target;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.instr_addr = pc_q;
    assign bus.opcode     = (state_q == RUN) ? instr_op : '0;
    assign bus.running    = (state_q == RUN);
    assign bus.done       = (state_q == HALTED);

`ifdef FETCH_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (start_ok) begin
            cnt_q <= '0;
        end else if ((state_q == RUN) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.cycle_count = cnt_q;
`endif

endmodule
